// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// Multiplies by radix-2 shift-add and divides by restoring subtract-shift,
// always on operand magnitudes, and applies sign correction in the final
// cycle. Latency is fixed at WIDTH+1 cycles from the accepting edge to done.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;

  // Operation context captured on the accepting edge
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             b_zero_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] lsr_q;

  logic             accept;
  logic             wr_hi;
  logic             wr_lo;
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Two's-complement negation when n is set; used for magnitudes and sign fix-up
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic n);
    return n ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic n);
    return n ? ({(2*WIDTH){1'b0}} - v) : v;
  endfunction

  // Request decode; start is honoured only in IDLE and never on the first
  // edge after reset release
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op && ($signed(a) < 0);
    b_neg     = signed_op && ($signed(b) < 0);
    mag_a     = cond_neg(a, a_neg);
    mag_b     = cond_neg(b, b_neg);
    accept    = (state_q == IDLE) && armed_q && start && !op[2];
    wr_hi     = (state_q == IDLE) && armed_q && start && (op == OP_MTHI);
    wr_lo     = (state_q == IDLE) && armed_q && start && (op == OP_MTLO);
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lsr_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, lsr_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  end

  // Final sign correction and divide-by-zero substitution
  always_comb begin
    prod_fix = cond_neg2({acc_q, lsr_q}, neg_res_q);
    quo_fix  = cond_neg(lsr_q, neg_res_q);
    rem_fix  = cond_neg(acc_q, neg_rem_q);
    if (!is_div_q) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (b_zero_q) begin
      res_hi = a_q;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      armed_q <= 1'b1;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            cnt_q <= CNT_W'(WIDTH);
          end
          if (wr_hi) hi <= a;
          if (wr_lo) lo <= a;
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          hi   <= res_hi;
          lo   <= res_lo;
          if (is_div_q) div_zero <= b_zero_q;
        end
        default: ;
      endcase
    end
  end

  // Iteration datapath: operands latched on accept, stepped once per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_q  <= op[1];
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      b_zero_q  <= (b == '0);
      a_q       <= a;
      acc_q     <= '0;
      if (op[1]) begin
        opnd_q <= mag_b;
        lsr_q  <= mag_a;
      end else begin
        opnd_q <= mag_a;
        lsr_q  <= mag_b;
      end
    end else if (state_q == RUN) begin
      if (is_div_q) begin
        acc_q <= div_ge ? div_sub : div_shift[WIDTH-1:0];
        lsr_q <= {lsr_q[WIDTH-2:0], div_ge};
      end else begin
        acc_q <= mul_sum[WIDTH:1];
        lsr_q <= {mul_sum[0], lsr_q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one arithmetic op; returns edges from accept to done (-1 on timeout)
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, output int lat,
                       output logic busy_acc);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    busy_acc = busy;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_divz got %b exp 0", div_zero); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
  endtask

  task automatic test_first_edge;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; op = 3'b101; a = 32'h55;
    @(posedge clk); #1;
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL first_edge_ignored got %h exp 0", lo); end
    a = 32'h77;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (lo !== 32'h77) begin errors++; $display("FAIL second_edge_mtlo got %h exp 77", lo); end
  endtask

  task automatic test_mthi_mtlo;
    start = 1'b1; op = 3'b100; a = 32'h1111_1111;
    @(posedge clk); #1;
    checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL mthi got %h exp 11111111", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags got busy %b done %b exp 0 0", busy, done); end
    op = 3'b101; a = 32'h2222_2222;
    @(posedge clk); #1;
    checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL mtlo got %h exp 22222222", lo); end
    checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL mtlo_hi_hold got %h exp 11111111", hi); end
    op = 3'b110; a = 32'h3333_3333;
    @(posedge clk); #1;
    op = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin errors++; $display("FAIL noop got hi %h lo %h exp 11111111 22222222", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop_busy got %b exp 0", busy); end
  endtask

  task automatic test_multu;
    int lat; logic ba;
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ba);
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL multu_busy got %b exp 1", ba); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d exp 33", lat); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_clear got %b exp 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_width got %b exp 0", done); end
  endtask

  task automatic test_mult;
    int lat; logic ba;
    do_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, lat, ba);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d exp 33", lat); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", lo); end
  endtask

  task automatic test_div;
    int lat; logic ba;
    do_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, lat, ba);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_dz got %b exp 0", div_zero); end
    do_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, lat, ba);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL div_negb_hi got %h exp 00000001", hi); end
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, ba);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
    checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi got %h exp 00000000", hi); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_dz got %b exp 0", div_zero); end
  endtask

  task automatic test_div_zero;
    int lat; logic ba;
    do_op(3'b011, 32'h0000_1234, 32'h0000_0000, lat, ba);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divz_latency got %0d exp 33", lat); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL divz_hi got %h exp 00001234", hi); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divz_flag got %b exp 1", div_zero); end
    do_op(3'b001, 32'h0000_0003, 32'h0000_0004, lat, ba);
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divz_hold got %b exp 1", div_zero); end
    checks++; if (lo !== 32'h0000_000C) begin errors++; $display("FAIL divz_mul_lo got %h exp 0000000c", lo); end
    do_op(3'b011, 32'd100, 32'd7, lat, ba);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL divz_clear got %b exp 0", div_zero); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_100_7 got lo %h hi %h exp 0000000e 00000002", lo, hi); end
  endtask

  task automatic test_start_in_run;
    int pulses; logic busy_mid;
    pulses = 0; busy_mid = 1'b0;
    start = 1'b1; op = 3'b001; a = 32'h0001_0000; b = 32'h0001_0000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (n == 5) begin
        start = 1'b1; op = 3'b100; a = 32'h0000_DEAD;
      end
      if (n == 6) begin
        start = 1'b0;
        busy_mid = busy;
      end
    end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL run_ignore_busy got %b exp 1", busy_mid); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL run_ignore_pulses got %0d exp 1", pulses); end
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL run_ignore_hi got %h exp 00000001", hi); end
    checks++; if (lo !== 32'h0000_0000) begin errors++; $display("FAIL run_ignore_lo got %h exp 00000000", lo); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2; logic ba1, ba2, done_at_accept;
    do_op(3'b001, 32'd6, 32'd7, lat1, ba1);
    done_at_accept = done;
    do_op(3'b011, 32'd50, 32'd8, lat2, ba2);
    checks++; if (done_at_accept !== 1'b1 || lat1 !== 33) begin errors++; $display("FAIL b2b_first got done %b lat %0d exp 1 33", done_at_accept, lat1); end
    checks++; if (ba2 !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", ba2); end
    checks++; if (lat2 !== 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", lat2); end
    checks++; if (lo !== 32'd6 || hi !== 32'd2) begin errors++; $display("FAIL b2b_result got lo %h hi %h exp 00000006 00000002", lo, hi); end
  endtask

  task automatic test_reset_mid_div;
    int pulses;
    pulses = 0;
    start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rst_mid_hilo got hi %h lo %h exp 0 0", hi, lo); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_done got %0d pulses exp 0", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got busy %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_mthi_mtlo();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_start_in_run();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand and HI/LO register width (legal values: 8, 16, 32, 64).
REQ-002 The block SHALL take parameter CNT_W, default $clog2(WIDTH)+1, as the iteration counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled on a rising edge.
REQ-006 The block SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-007 The block SHALL have port a, input, WIDTH bits: multiplicand or dividend, or the source operand for MTHI/MTLO.
REQ-008 The block SHALL have port b, input, WIDTH bits: multiplier or divisor.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an iterative operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when the HI/LO results are valid.
REQ-011 The block SHALL have port div_zero, output, 1 bit: set when the last DIV or DIVU had b==0.
REQ-012 The block SHALL have port hi, output, WIDTH bits: the HI register.
REQ-013 The block SHALL have port lo, output, WIDTH bits: the LO register.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-015 In IDLE, a rising edge with start=1 and op in 000..011 SHALL latch a, b and op, set busy=1, load the counter with WIDTH and enter RUN.
REQ-016 In IDLE, start=1 with op=100 or op=101 SHALL write a into hi or lo respectively on that same edge; busy and done SHALL stay 0.
REQ-017 start SHALL be ignored in RUN and FINISH, including MTHI and MTLO; latched operands SHALL NOT change while busy=1.
REQ-018 RUN SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle on operand magnitudes, for exactly WIDTH cycles, then enter FINISH.
REQ-019 FINISH SHALL apply the sign correction, write hi and lo, clear busy, assert done for exactly that one cycle and return to IDLE.
REQ-020 Latency SHALL be fixed: if start is accepted at edge k, done SHALL be high during the cycle following edge k+WIDTH+1, for every operand value including b==0.
REQ-021 A new start SHALL be accepted on the edge at which done is high, giving back-to-back operation.
REQ-022 MULT and MULTU SHALL produce the full 2*WIDTH-bit product: upper half to hi, lower half to lo. MULT treats operands as two's complement; MULTU as unsigned.
REQ-023 DIV and DIVU SHALL write the quotient to lo and the remainder to hi.
REQ-024 Signed division SHALL truncate toward zero; the quotient is negative if and only if the operand signs differ, and the remainder takes the sign of the dividend.
REQ-025 DIV with the most-negative a and b=-1 SHALL give lo equal to the most-negative value and hi equal to 0, with no error flag.
REQ-026 Division with b==0 SHALL give lo equal to all ones, hi equal to a (unmodified), and div_zero=1.
REQ-027 div_zero SHALL update only in FINISH of a DIV or DIVU and SHALL hold its value otherwise.
REQ-028 hi and lo SHALL change only in FINISH or on an MTHI/MTLO write, and SHALL hold their values at all other times.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state to IDLE, and busy, done, div_zero, hi, lo and the counter to 0.
REQ-030 A reset asserted during RUN or FINISH SHALL abandon the operation; no done pulse SHALL occur for it.
REQ-031 start SHALL be ignored on the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-032 Directed test: MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after the accepting edge.
REQ-033 Directed test: MULT with a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 Directed test: DIV with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-035 Directed test: DIVU with a=0x00001234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234, div_zero=1, latency unchanged.
REQ-036 Directed test: during RUN, apply start with op=100 and a=0xDEAD -> ignored; hi equals the arithmetic result after done, and exactly one done pulse occurs.
REQ-037 Directed test: assert rst_n=0 ten cycles into a DIV -> busy, hi and lo read 0 immediately with no clock edge, and no done pulse follows.
